// File: rtl/bus_pkg.sv
// Shared bus definitions for the AXI-Lite master arbiter.
//   arb_state_e : arbiter FSM states (IDLE / BUSY / RECOVER)
//   M_ICACHE / M_DCACHE / M_DMA : master index assignments
//   NUM_M_DEFAULT : default number of bus masters
package bus_pkg;

  localparam int unsigned NUM_M_DEFAULT = 3;

  localparam int unsigned M_ICACHE = 0;
  localparam int unsigned M_DCACHE = 1;
  localparam int unsigned M_DMA    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_age_counter.sv
// Per-master saturating wait counter.
// Counts cycles a master requests without holding the grant; saturates at
// LIMIT and flags the master as starving while saturated.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req        : master request level
//   i_granted    : master currently holds the grant
//   o_starving   : counter saturated at LIMIT
module arb_age_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_granted,
  output logic o_starving
);

  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_req || i_granted) begin
      r_count <= '0;
    end else if (r_count != LIM) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_starving = (r_count == LIM);

endmodule

// File: rtl/axil_arbiter.sv
// AXI-Lite bus arbiter for NUM_M masters (0 = I-cache, 1 = D-cache, 2 = DMA).
// Fixed priority (higher index wins) with starvation promotion, one grant at a
// time held until the fabric reports completion, and a transaction timeout.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req          : per-master request level, held until granted
//   done         : one-cycle completion pulse for the granted transaction
//   grant        : registered one-hot grant
//   grant_idx    : encoded index of the active grant (0 when idle)
//   busy         : a grant is active
//   timeout_err  : one-cycle pulse when a transaction is aborted
//   err_idx      : master of the last aborted transaction, held
module axil_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_M        = NUM_M_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_M-1:0]                      req,
  input  logic                                  done,
  output logic [NUM_M-1:0]                      grant,
  output logic [((NUM_M > 1) ? $clog2(NUM_M) : 1)-1:0] grant_idx,
  output logic                                  busy,
  output logic                                  timeout_err,
  output logic [((NUM_M > 1) ? $clog2(NUM_M) : 1)-1:0] err_idx
);

  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  arb_state_e       r_state;
  logic [NUM_M-1:0] r_grant;
  logic [IW-1:0]    r_grant_idx;
  logic             r_timeout_err;
  logic [IW-1:0]    r_err_idx;
  logic [TW-1:0]    r_tcnt;
  // Holds off arbitration for the first edge after reset release so the
  // earliest grant lands on the second rising edge.
  logic             r_armed;

  logic [NUM_M-1:0] w_starving;
  logic [NUM_M-1:0] w_cand;
  logic [NUM_M-1:0] w_win_oh;
  logic [IW-1:0]    w_win_idx;

  for (genvar g = 0; g < NUM_M; g++) begin : g_age
    arb_age_counter #(
      .LIMIT(STARVE_LIMIT)
    ) u_age (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req[g]),
      .i_granted (r_grant[g]),
      .o_starving(w_starving[g])
    );
  end

  // Starving requesters form the candidate set when any exist; otherwise all
  // requesters do. The highest-index candidate wins (ascending scan, last hit).
  always_comb begin
    w_cand    = ((req & w_starving) != '0) ? (req & w_starving) : req;
    w_win_oh  = '0;
    w_win_idx = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (w_cand[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_timeout_err <= 1'b0;
      r_err_idx     <= '0;
      r_tcnt        <= '0;
      r_armed       <= 1'b0;
    end else begin
      r_armed       <= 1'b1;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_armed && (req != '0)) begin
            r_grant     <= w_win_oh;
            r_grant_idx <= w_win_idx;
            r_tcnt      <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          // done takes precedence over a coincident timeout
          if (done) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_state     <= IDLE;
          end else if (r_tcnt == TMAX) begin
            r_timeout_err <= 1'b1;
            r_err_idx     <= r_grant_idx;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_state       <= RECOVER;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
        end
        default: begin
          r_grant     <= '0;
          r_grant_idx <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign busy        = |r_grant;
  assign timeout_err = r_timeout_err;
  assign err_idx     = r_err_idx;

endmodule

// File: tb/tb_axil_arbiter.sv
// Self-checking bench for axil_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_axil_arbiter;

  localparam int SL = 16;
  localparam int TO = 256;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout_err;
  logic [1:0] err_idx;

  int n_asserts = 0;
  int n_fail    = 0;

  // reference model state
  int m_owner;       // -1 when no grant
  int m_open;        // cycles the current grant has been open, minus one
  int m_wait[3];
  bit m_recover;
  bit m_armed;
  bit m_terr;
  int m_err;

  axil_arbiter #(
    .NUM_M       (3),
    .STARVE_LIMIT(SL),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_idx    (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // grant must be zero or one-hot and busy must mirror it, every cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_asserts++;
      assert ($onehot0(grant) && (busy === (|grant))) else begin
        n_fail++;
        $error("FAIL onehot: observed grant=%b busy=%b expected zero/one-hot with busy=|grant", grant, busy);
      end
    end
  end

  task automatic model_reset();
    m_owner = -1; m_open = 0; m_recover = 0; m_armed = 0; m_terr = 0; m_err = 0;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic d);
    int nw[3];
    int win;
    for (int i = 0; i < 3; i++)
      nw[i] = (r[i] && m_owner != i) ? ((m_wait[i] + 1 > SL) ? SL : m_wait[i] + 1) : 0;
    m_terr = 0;
    if (m_owner >= 0) begin
      if (d) m_owner = -1;
      else if (m_open == TO - 1) begin
        m_terr = 1; m_err = m_owner; m_owner = -1; m_recover = 1;
      end else m_open++;
    end else if (m_recover) begin
      m_recover = 0;
    end else if (m_armed && r != 3'b000) begin
      win = -1;
      for (int i = 0; i < 3; i++) if (r[i] && m_wait[i] == SL) win = i;
      if (win < 0) for (int i = 0; i < 3; i++) if (r[i]) win = i;
      m_owner = win; m_open = 0;
    end
    for (int i = 0; i < 3; i++) m_wait[i] = nw[i];
    m_armed = 1;
  endtask

  task automatic check_model();
    logic [2:0] eg;
    eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    chk("grant", grant, eg);
    chk("grant_idx", grant_idx, (m_owner >= 0) ? m_owner : 0);
    chk("busy", busy, m_owner >= 0);
    chk("timeout_err", timeout_err, m_terr);
    chk("err_idx", err_idx, m_err);
  endtask

  task automatic cyc(input logic [2:0] r, input logic d);
    @(negedge clk);
    req = r; done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++)
      if (m_owner >= 0 || m_recover) cyc(3'b000, 1'b1);
  endtask

  initial begin
    bit found;
    logic [2:0] r;
    logic d;

    req = '0; done = 1'b0; rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_grant", grant, 3'b000);
    chk("rst_grant_idx", grant_idx, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_err_idx", err_idx, 2'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // first edge after release must not grant
    cyc(3'b001, 1'b0);
    chk("post_rst_no_grant", grant, 3'b000);
    cyc(3'b001, 1'b0);
    chk("post_rst_grant", grant, 3'b001);
    drain();

    // done while idle is ignored
    cyc(3'b000, 1'b1);
    chk("idle_done_ignored", grant, 3'b000);

    // D-cache beats I-cache; one idle cycle between grants
    cyc(3'b011, 1'b0);
    chk("s1_grant_dc", grant, 3'b010);
    repeat (3) cyc(3'b011, 1'b0);
    cyc(3'b001, 1'b1);
    chk("s1_gap", grant, 3'b000);
    cyc(3'b001, 1'b0);
    chk("s1_grant_ic", grant, 3'b001);
    drain();

    // granted request drops mid-transaction; grant held until done
    cyc(3'b010, 1'b0);
    repeat (3) cyc(3'b000, 1'b0);
    chk("hold_grant", grant, 3'b010);
    cyc(3'b000, 1'b1);
    chk("hold_release", grant, 3'b000);
    cyc(3'b000, 1'b0);

    // starvation: DMA requesting continuously, I-cache must get in
    found = 0;
    for (int k = 0; k < SL + 4; k++) begin
      if (!found) begin
        cyc(3'b101, m_owner >= 0);
        if (grant === 3'b001) found = 1;
      end
    end
    chk("starve_icache_granted", found, 1'b1);
    drain();
    cyc(3'b000, 1'b0);

    // timeout on D-cache
    cyc(3'b010, 1'b0);
    repeat (TO - 1) cyc(3'b000, 1'b0);
    chk("to_still_granted", grant, 3'b010);
    cyc(3'b000, 1'b0);
    chk("to_pulse", timeout_err, 1'b1);
    chk("to_err_idx", err_idx, 2'd1);
    chk("to_recover_grant", grant, 3'b000);
    cyc(3'b100, 1'b0);
    chk("to_pulse_end", timeout_err, 1'b0);
    chk("to_recover_no_grant", grant, 3'b000);
    cyc(3'b100, 1'b0);
    chk("to_after_recover", grant, 3'b100);
    drain();
    cyc(3'b000, 1'b0);

    // done coinciding with the timeout condition wins
    cyc(3'b010, 1'b0);
    repeat (TO - 1) cyc(3'b000, 1'b0);
    cyc(3'b000, 1'b1);
    chk("coin_no_err", timeout_err, 1'b0);
    chk("coin_grant", grant, 3'b000);
    chk("coin_err_idx_held", err_idx, 2'd1);
    cyc(3'b000, 1'b0);

    // asynchronous reset while DMA holds the grant
    cyc(3'b100, 1'b0);
    chk("arst_pre", grant, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 3'b000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_terr", timeout_err, 1'b0);
    chk("arst_err_idx", err_idx, 2'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(3'b100, 1'b0);
    chk("arst_rel_no_grant", grant, 3'b000);
    cyc(3'b100, 1'b0);
    chk("arst_rel_grant", grant, 3'b100);

    // randomized traffic; requests held until granted
    r = 3'b100;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 3; i++)
        if (!(r[i] && m_owner != i)) r[i] = ($urandom_range(0, 2) == 0);
      if (m_owner >= 0) d = ($urandom_range(0, 3) == 0);
      else d = ($urandom_range(0, 7) == 0);
      cyc(r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
